// File: rtl/servo_tick_gen_if.sv
// Divisor-write bus, run enables and per-channel tick/square/pending outputs of servo_tick_gen.
// master = controller side, slave = the tick generator.
interface servo_tick_gen_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DIV_W-1:0]  wr_div;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq_out;
  logic [NUM_CH-1:0] pend;

  modport master (
    output wr_en, wr_ch, wr_div, ch_en,
    input  tick, sq_out, pend
  );

  modport slave (
    input  wr_en, wr_ch, wr_div, ch_en,
    output tick, sq_out, pend
  );
endinterface

// File: rtl/servo_tick_gen.sv
// Multi-channel clock-enable generator: per-channel tick pulse and 50% square from a programmable divisor.
// TICKGEN_SYNC_EN adds sync_req, which zeroes every counter and applies pending divisors at once.
module servo_tick_gen #(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 16,
  parameter int RESET_DIV = 250
) (
  input  logic clk,
  input  logic reset,
`ifdef TICKGEN_SYNC_EN
  input  logic sync_req,
`endif
  servo_tick_gen_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_d [NUM_CH];
  logic [DIV_W-1:0]  act_q [NUM_CH];
  logic [DIV_W-1:0]  act_d [NUM_CH];
  logic [DIV_W-1:0]  nxt_q [NUM_CH];
  logic [DIV_W-1:0]  nxt_d [NUM_CH];
  logic [NUM_CH-1:0] pflag_q, pflag_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] sq_q, sq_d;
  logic [NUM_CH-1:0] run_w, wrap_w, wr_hit_w;
  logic              sync_w;

`ifdef TICKGEN_SYNC_EN
  assign sync_w = sync_req;
`else
  assign sync_w = 1'b0;
`endif

  always_comb begin
    run_w    = '0;
    wrap_w   = '0;
    wr_hit_w = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      run_w[i]    = bus.ch_en[i] && (act_q[i] != '0);
      wrap_w[i]   = run_w[i] && (cnt_q[i] == act_q[i] - DIV_W'(1));
      wr_hit_w[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    act_d   = act_q;
    nxt_d   = nxt_q;
    pflag_d = pflag_q;
    tick_d  = tick_q;
    sq_d    = sq_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync_w) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b0;
        sq_d[i]   = 1'b0;
        if (pflag_q[i]) begin
          act_d[i]   = nxt_q[i];
          pflag_d[i] = 1'b0;
        end
      end else begin
        if (!bus.ch_en[i]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b0;
          sq_d[i]   = 1'b0;
        end else if (act_q[i] == '0) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b0;
        end else if (wrap_w[i]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          sq_d[i]   = ~sq_q[i];
        end else begin
          cnt_d[i]  = cnt_q[i] + DIV_W'(1);
          tick_d[i] = 1'b0;
        end
        // Swap divisors only at a period boundary or while idle so no period is ever truncated.
        if (pflag_q[i] && (!run_w[i] || wrap_w[i])) begin
          act_d[i]   = nxt_q[i];
          pflag_d[i] = 1'b0;
        end
      end
      // A write in the same cycle as a swap queues behind it rather than replacing it.
      if (wr_hit_w[i]) begin
        nxt_d[i]   = bus.wr_div;
        pflag_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= DIV_W'(RESET_DIV);
        nxt_q[i] <= '0;
      end
      pflag_q <= '0;
      tick_q  <= '0;
      sq_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      nxt_q   <= nxt_d;
      pflag_q <= pflag_d;
      tick_q  <= tick_d;
      sq_q    <= sq_d;
    end
  end

  assign bus.tick   = tick_q;
  assign bus.sq_out = sq_q;
  assign bus.pend   = pflag_q;
endmodule

// File: tb/tb_servo_tick_gen.sv
// Bench for servo_tick_gen: per-cycle vector table on small divisors, plus sequences for
// default rate, mid-period divisor change, optional sync and asynchronous reset.
module tb_servo_tick_gen;
  localparam int NCH = 5;

  logic clk;
  logic reset;
`ifdef TICKGEN_SYNC_EN
  logic sync_req;
`endif

  servo_tick_gen_if #(.NUM_CH(NCH), .DIV_W(16)) bus ();

  servo_tick_gen #(.NUM_CH(NCH), .DIV_W(16), .RESET_DIV(250)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef TICKGEN_SYNC_EN
    .sync_req (sync_req),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [15:0] wr_div;
    logic [4:0]  ch_en;
    logic [4:0]  tick;
    logic [4:0]  sq;
    logic [4:0]  pend;
  } vec_t;

  vec_t vecs [30];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic do_reset();
    bus.wr_en  = 1'b0;
    bus.wr_ch  = '0;
    bus.wr_div = '0;
    bus.ch_en  = '0;
`ifdef TICKGEN_SYNC_EN
    sync_req   = 1'b0;
`endif
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Edges counted from the next rising edge until tick[ch] is seen; -1 on timeout.
  task automatic wait_tick(input int ch, input int limit, output int n);
    n = -1;
    for (int e = 1; e <= limit; e++) begin
      @(posedge clk);
      #1;
      if (bus.tick[ch]) begin
        n = e;
        break;
      end
    end
  endtask

  task automatic write_div(input int ch, input int div);
    @(negedge clk);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 3'(ch);
    bus.wr_div = 16'(div);
    @(negedge clk);
    bus.wr_en  = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int errs;
    logic exp_t;

    //            wr  ch    div     ch_en     tick      sq        pend
    vecs[0]  = '{1'b1, 3'd1, 16'd3, 5'b00000, 5'b00000, 5'b00000, 5'b00010};
    vecs[1]  = '{1'b0, 3'd0, 16'd0, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    vecs[2]  = '{1'b0, 3'd0, 16'd0, 5'b00010, 5'b00000, 5'b00000, 5'b00000};
    vecs[3]  = '{1'b0, 3'd0, 16'd0, 5'b00010, 5'b00000, 5'b00000, 5'b00000};
    vecs[4]  = '{1'b0, 3'd0, 16'd0, 5'b00010, 5'b00010, 5'b00010, 5'b00000};
    vecs[5]  = '{1'b0, 3'd0, 16'd0, 5'b00010, 5'b00000, 5'b00010, 5'b00000};
    vecs[6]  = '{1'b0, 3'd0, 16'd0, 5'b00010, 5'b00000, 5'b00010, 5'b00000};
    vecs[7]  = '{1'b0, 3'd0, 16'd0, 5'b00010, 5'b00010, 5'b00000, 5'b00000};
    vecs[8]  = '{1'b1, 3'd2, 16'd1, 5'b00010, 5'b00000, 5'b00000, 5'b00100};
    vecs[9]  = '{1'b0, 3'd0, 16'd0, 5'b00010, 5'b00000, 5'b00000, 5'b00000};
    vecs[10] = '{1'b0, 3'd0, 16'd0, 5'b00110, 5'b00110, 5'b00110, 5'b00000};
    vecs[11] = '{1'b1, 3'd2, 16'd0, 5'b00110, 5'b00100, 5'b00010, 5'b00100};
    vecs[12] = '{1'b0, 3'd0, 16'd0, 5'b00110, 5'b00100, 5'b00110, 5'b00000};
    vecs[13] = '{1'b0, 3'd0, 16'd0, 5'b00110, 5'b00010, 5'b00100, 5'b00000};
    vecs[14] = '{1'b1, 3'd2, 16'd1, 5'b00110, 5'b00000, 5'b00100, 5'b00100};
    vecs[15] = '{1'b0, 3'd0, 16'd0, 5'b00110, 5'b00000, 5'b00100, 5'b00000};
    vecs[16] = '{1'b0, 3'd0, 16'd0, 5'b00110, 5'b00110, 5'b00010, 5'b00000};
    vecs[17] = '{1'b1, 3'd5, 16'd7, 5'b00110, 5'b00100, 5'b00110, 5'b00000};
    vecs[18] = '{1'b0, 3'd0, 16'd0, 5'b00100, 5'b00100, 5'b00000, 5'b00000};
    vecs[19] = '{1'b0, 3'd0, 16'd0, 5'b00110, 5'b00100, 5'b00100, 5'b00000};
    vecs[20] = '{1'b0, 3'd0, 16'd0, 5'b00110, 5'b00100, 5'b00000, 5'b00000};
    vecs[21] = '{1'b0, 3'd0, 16'd0, 5'b00110, 5'b00110, 5'b00110, 5'b00000};
    vecs[22] = '{1'b1, 3'd1, 16'd2, 5'b00110, 5'b00100, 5'b00010, 5'b00010};
    vecs[23] = '{1'b1, 3'd1, 16'd5, 5'b00110, 5'b00100, 5'b00110, 5'b00010};
    vecs[24] = '{1'b1, 3'd1, 16'd4, 5'b00110, 5'b00110, 5'b00000, 5'b00010};
    vecs[25] = '{1'b0, 3'd0, 16'd0, 5'b00110, 5'b00100, 5'b00100, 5'b00010};
    vecs[26] = '{1'b0, 3'd0, 16'd0, 5'b00110, 5'b00100, 5'b00000, 5'b00010};
    vecs[27] = '{1'b0, 3'd0, 16'd0, 5'b00110, 5'b00100, 5'b00100, 5'b00010};
    vecs[28] = '{1'b0, 3'd0, 16'd0, 5'b00110, 5'b00100, 5'b00000, 5'b00010};
    vecs[29] = '{1'b0, 3'd0, 16'd0, 5'b00110, 5'b00110, 5'b00110, 5'b00000};

    do_reset();
    #1;
    check("reset tick", 32'(bus.tick), 32'd0);
    check("reset sq_out", 32'(bus.sq_out), 32'd0);
    check("reset pend", 32'(bus.pend), 32'd0);

    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      bus.wr_en  = vecs[k].wr_en;
      bus.wr_ch  = vecs[k].wr_ch;
      bus.wr_div = vecs[k].wr_div;
      bus.ch_en  = vecs[k].ch_en;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d tick", k), 32'(bus.tick), 32'(vecs[k].tick));
      check($sformatf("vec%0d sq_out", k), 32'(bus.sq_out), 32'(vecs[k].sq));
      check($sformatf("vec%0d pend", k), 32'(bus.pend), 32'(vecs[k].pend));
    end

    // Default divisor on ch0.
    do_reset();
    @(negedge clk);
    bus.ch_en = 5'b00001;
    wait_tick(0, 600, n);
    check("ch0 first tick edge", 32'(n), 32'd250);
    check("ch0 sq after tick1", 32'(bus.sq_out[0]), 32'd1);
    wait_tick(0, 600, n);
    check("ch0 tick period", 32'(n), 32'd250);
    check("ch0 sq after tick2", 32'(bus.sq_out[0]), 32'd0);
    wait_tick(0, 600, n);
    check("ch0 tick period 3", 32'(n), 32'd250);
    check("ch0 sq after tick3", 32'(bus.sq_out[0]), 32'd1);

    // ch1 D=10, rewritten to 4 mid-period.
    do_reset();
    write_div(1, 10);
    errs = 0;
    for (int e = 1; e <= 22; e++) begin
      @(negedge clk);
      bus.ch_en  = 5'b00010;
      bus.wr_en  = (e == 4);
      bus.wr_ch  = 3'd1;
      bus.wr_div = 16'd4;
      @(posedge clk);
      #1;
      exp_t = (e == 10) || (e == 14) || (e == 18) || (e == 22);
      if (bus.tick[1] !== exp_t) errs++;
      if (e == 4)  check("ch1 pend after write", 32'(bus.pend[1]), 32'd1);
      if (e == 9)  check("ch1 pend before wrap", 32'(bus.pend[1]), 32'd1);
      if (e == 10) check("ch1 pend after wrap", 32'(bus.pend[1]), 32'd0);
    end
    check("ch1 tick spacing 10 then 4", 32'(errs), 32'd0);
    @(negedge clk);
    bus.wr_en = 1'b0;

`ifdef TICKGEN_SYNC_EN
    do_reset();
    write_div(0, 5);
    write_div(1, 7);
    @(negedge clk);
    bus.ch_en = 5'b00011;
    repeat (13) @(posedge clk);
    #1;
    check("pre-sync sq1", 32'(bus.sq_out[1]), 32'd1);
    @(negedge clk);
    sync_req = 1'b1;
    @(posedge clk);
    #1;
    check("sync tick", 32'(bus.tick[1:0]), 32'd0);
    check("sync sq_out", 32'(bus.sq_out[1:0]), 32'd0);
    @(negedge clk);
    sync_req = 1'b0;
    begin
      int t0, t1;
      t0 = -1;
      t1 = -1;
      for (int e = 1; e <= 20; e++) begin
        @(posedge clk);
        #1;
        if (bus.tick[0] && t0 < 0) t0 = e;
        if (bus.tick[1] && t1 < 0) t1 = e;
      end
      check("sync ch0 first tick", 32'(t0), 32'd5);
      check("sync ch1 first tick", 32'(t1), 32'd7);
    end
`endif

    // Asynchronous reset mid-period with writes pending.
    do_reset();
    write_div(4, 1);
    @(negedge clk);
    bus.ch_en = 5'b11111;
    repeat (21) @(posedge clk);
    #1;
    check("pre-reset ch4 tick", 32'(bus.tick[4]), 32'd1);
    check("pre-reset ch4 sq", 32'(bus.sq_out[4]), 32'd1);
    write_div(0, 9);
    write_div(3, 12);
    check("pre-reset pend", 32'(bus.pend), 32'b01001);
    #2;
    reset = 1'b0;
    #1;
    check("async reset tick", 32'(bus.tick), 32'd0);
    check("async reset sq_out", 32'(bus.sq_out), 32'd0);
    check("async reset pend", 32'(bus.pend), 32'd0);
    @(negedge clk);
    bus.ch_en = 5'b00000;
    reset = 1'b1;
    @(negedge clk);
    bus.ch_en = 5'b00001;
    wait_tick(0, 600, n);
    check("post-reset ch0 period", 32'(n), 32'd250);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
